mem_access_unit: RTL and testbench

- Parametrised, sequential load/store unit between the CPU datapath and a word-wide data memory.
- Handles byte, halfword, word and (when DATA_W=64) doubleword accesses at any legal byte offset.
- Loads are sign- or zero-extended. Partial stores use an internal read-modify-write sequence.
- Detects misaligned accesses and reports them as errors without touching memory.

---
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - sequential load/store unit with sign/zero extension and RMW partial stores
// Misaligned or illegal-size requests respond with an error and never reach memory.
module mem_access_unit #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);
   localparam int NB   = DATA_W / 8;
   localparam int OFFW = $clog2(NB);
   localparam int IDXW = $clog2(DATA_W);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

   state_t            r_state;
   logic              r_req_ready;
   logic              r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_rd;
   logic              r_mem_wr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_write;
   logic [1:0]        r_size;
   logic              r_signed;
   logic [OFFW-1:0]   r_off;
   logic [DATA_W-1:0] r_wdata;

   logic [OFFW-1:0]   w_align;
   logic              w_size_bad;
   logic              w_misal;
   logic              w_full;
   logic [IDXW-1:0]   w_sh;
   logic [IDXW-1:0]   w_msb;
   logic [DATA_W-1:0] w_lo_mask;
   logic [DATA_W-1:0] w_lane;
   logic [DATA_W-1:0] w_shifted;
   logic              w_sign;
   logic [DATA_W-1:0] w_ext;
   logic [DATA_W-1:0] w_merge;

   assign w_align    = OFFW'((32'd1 << req_size) - 32'd1);
   assign w_size_bad = (DATA_W == 32) && (req_size == 2'd3);
   assign w_misal    = (req_addr[OFFW-1:0] & w_align) != '0;
   assign w_full     = (req_size == 2'(OFFW));

   // Lane mask covers the low 2^size bytes; shifting by a full width yields all ones.
   assign w_sh      = {r_off, 3'b000};
   assign w_lo_mask = ~({DATA_W{1'b1}} << (32'd8 << r_size));
   assign w_msb     = IDXW'((32'd8 << r_size) - 32'd1);
   assign w_shifted = mem_rdata >> w_sh;
   assign w_sign    = r_signed & w_shifted[w_msb];
   assign w_ext     = (w_shifted & w_lo_mask) | (w_sign ? ~w_lo_mask : '0);
   assign w_lane    = w_lo_mask << w_sh;
   assign w_merge   = (mem_rdata & ~w_lane) | ((r_wdata << w_sh) & w_lane);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_rd    <= 1'b0;
         r_mem_wr    <= 1'b0;
         r_mem_wdata <= '0;
         r_write     <= 1'b0;
         r_size      <= 2'd0;
         r_signed    <= 1'b0;
         r_off       <= '0;
         r_wdata     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_write     <= req_write;
                  r_size      <= req_size;
                  r_signed    <= req_signed;
                  r_off       <= req_addr[OFFW-1:0];
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  r_mem_addr  <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                  if (w_size_bad || w_misal) begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_rdata <= '0;
                  end else if (!req_write || !w_full) begin
                     r_state  <= S_RD;
                     r_mem_rd <= 1'b1;
                  end else begin
                     r_state     <= S_WR;
                     r_mem_wr    <= 1'b1;
                     r_mem_wdata <= req_wdata;
                  end
               end
            end
            S_RD: begin
               if (mem_ack) begin
                  r_mem_rd <= 1'b0;
                  if (r_write) begin
                     r_state     <= S_WR;
                     r_mem_wr    <= 1'b1;
                     r_mem_wdata <= w_merge;
                  end else begin
                     r_state     <= S_RESP;
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b0;
                     r_rsp_rdata <= w_ext;
                  end
               end
            end
            S_WR: begin
               if (mem_ack) begin
                  r_mem_wr    <= 1'b0;
                  r_state     <= S_RESP;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= '0;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state     <= S_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_req_ready <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign mem_addr  = r_mem_addr;
   assign mem_rd    = r_mem_rd;
   assign mem_wr    = r_mem_wr;
   assign mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit (32-bit and 64-bit instances)
module tb_mem_access_unit;
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0, req_signed = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata;
   logic        mem_rd, mem_wr;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   logic        req_valid_b = 1'b0, req_ready_b, req_write_b = 1'b0, req_signed_b = 1'b0;
   logic [1:0]  req_size_b = 2'd0;
   logic [31:0] req_addr_b = '0;
   logic [63:0] req_wdata_b = '0;
   logic        rsp_valid_b, rsp_ready_b = 1'b0, rsp_err_b;
   logic [63:0] rsp_rdata_b, mem_wdata_b;
   logic [31:0] mem_addr_b;
   logic        mem_rd_b, mem_wr_b;
   logic [63:0] mem_rdata_b = '0;
   logic        mem_ack_b = 1'b0;
   logic [63:0] mem64_word = '0;

   mem_access_unit #(.DATA_W(32), .ADDR_W(32)) u_dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
      .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack));

   mem_access_unit #(.DATA_W(64), .ADDR_W(32)) u_dut64 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
      .req_write(req_write_b), .req_size(req_size_b), .req_signed(req_signed_b),
      .req_addr(req_addr_b), .req_wdata(req_wdata_b), .rsp_valid(rsp_valid_b),
      .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
      .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .mem_wdata(mem_wdata_b),
      .mem_rdata(mem_rdata_b), .mem_ack(mem_ack_b));

   int checks = 0;
   int errors = 0;

   bit [31:0] mem     [int unsigned];
   bit [31:0] ref_mem [int unsigned];
   int        ack_delay = 0;
   int        wait_cnt = 0;
   int        n_rd = 0, n_wr = 0, n_both = 0, n_unstable = 0, n_ready_bad = 0;
   logic [31:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;
   logic        prev_rd = 1'b0, prev_wr = 1'b0;
   logic [31:0] prev_addr = '0, prev_wdata = '0;

   // Memory responder for the 32-bit instance: acks after ack_delay wait cycles.
   always @(negedge clk) begin
      if (mem_rd && mem_wr) n_both++;
      if ((mem_rd || mem_wr) && req_ready) n_ready_bad++;
      if (mem_rd) begin
         n_rd++;
         last_rd_addr = mem_addr;
         if (prev_rd && mem_addr !== prev_addr) n_unstable++;
      end
      if (mem_wr) begin
         n_wr++;
         last_wr_addr = mem_addr;
         last_wr_data = mem_wdata;
         if (prev_wr && (mem_addr !== prev_addr || mem_wdata !== prev_wdata)) n_unstable++;
      end
      prev_rd    = mem_rd;
      prev_wr    = mem_wr;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      if (mem_rd || mem_wr) begin
         if (wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem.exists(mem_addr >> 2) ? mem[mem_addr >> 2] : 32'h0;
            if (mem_wr) mem[mem_addr >> 2] = mem_wdata;
            wait_cnt  = 0;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            wait_cnt++;
         end
      end else begin
         mem_ack   = 1'b0;
         mem_rdata = $urandom;
         wait_cnt  = 0;
      end
   end

   always @(negedge clk) begin
      mem_ack_b   = mem_rd_b | mem_wr_b;
      mem_rdata_b = mem64_word;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] word, input int off,
                                            input int size, input bit sgn);
      logic [31:0] v;
      int n;
      v = '0;
      n = 1 << size;
      for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
      if (sgn && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] word, input int off,
                                             input int size, input logic [31:0] wdata);
      logic [31:0] v;
      v = word;
      for (int i = 0; i < (1 << size); i++) v[8*(off+i) +: 8] = wdata[8*i +: 8];
      return v;
   endfunction

   task automatic set_word(input int unsigned idx, input logic [31:0] v);
      mem[idx]     = v;
      ref_mem[idx] = v;
   endtask

   task automatic txn(input bit wr, input int size, input bit sgn, input logic [31:0] addr,
                      input logic [31:0] wdata, input int dly, input int hold,
                      output logic [31:0] got);
      int unsigned idx;
      int off, lat, exp_lat, exp_nrd, exp_nwr;
      int rd0, wr0, un0, b0, rb0;
      bit err, full;
      logic [31:0] exp_rd;
      idx  = addr >> 2;
      off  = int'(addr[1:0]);
      err  = (size == 3) || (off % (1 << size) != 0);
      full = (size == 2);
      if (!ref_mem.exists(idx)) set_word(idx, 32'h0);
      exp_rd  = (!err && !wr) ? ref_load(ref_mem[idx], off, size, sgn) : 32'h0;
      if (!err && wr) ref_mem[idx] = ref_store(ref_mem[idx], off, size, wdata);
      exp_lat = err ? 1 : ((!wr || full) ? 2 + dly : 3 + 2 * dly);
      exp_nrd = (err || (wr && full)) ? 0 : 1 + dly;
      exp_nwr = (err || !wr) ? 0 : 1 + dly;
      ack_delay = dly;
      rd0 = n_rd; wr0 = n_wr; un0 = n_unstable; b0 = n_both; rb0 = n_ready_bad;
      req_write = wr; req_size = size[1:0]; req_signed = sgn;
      req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      chk("req_ready_idle", req_ready, 1);
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         req_valid = 1'b0;
         lat++;
      end while (!rsp_valid && lat < 60);
      got = rsp_rdata;
      chk("latency", lat, exp_lat);
      chk("rsp_err", rsp_err, err);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rd_cycles", n_rd - rd0, exp_nrd);
      chk("wr_cycles", n_wr - wr0, exp_nwr);
      chk("strobe_stable", n_unstable - un0, 0);
      chk("no_overlap", n_both - b0, 0);
      chk("ready_low_busy", n_ready_bad - rb0, 0);
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1;
         req_addr  = $urandom;
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1);
         chk("hold_rdata", rsp_rdata, exp_rd);
         chk("hold_ready", req_ready, 0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_done", rsp_valid, 0);
      chk("ready_back", req_ready, 1);
      if (wr && !err) chk("mem_word", mem[idx], ref_mem[idx]);
   endtask

   task automatic t64(input int size, input bit sgn, input logic [31:0] addr,
                      output logic [63:0] rd, output logic err);
      int lat;
      req_write_b = 1'b0; req_size_b = size[1:0]; req_signed_b = sgn;
      req_addr_b = addr; req_valid_b = 1'b1;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         req_valid_b = 1'b0;
         lat++;
      end while (!rsp_valid_b && lat < 60);
      rd  = rsp_rdata_b;
      err = rsp_err_b;
      chk("d64_valid", rsp_valid_b, 1);
      rsp_ready_b = 1'b1;
      @(negedge clk);
      rsp_ready_b = 1'b0;
   endtask

   initial begin
      logic [31:0] got;
      logic [63:0] rd64;
      logic        err64;
      int          lat;

      repeat (2) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      reset_n = 1'b1;
      @(negedge clk);

      set_word(32'h40, 32'h80AA55CC);
      txn(1'b0, 0, 1'b1, 32'h103, 32'h0, 0, 0, got);
      chk("lb_value", got, 32'hFFFFFF80);
      chk("lb_mem_addr", last_rd_addr, 32'h100);
      txn(1'b0, 0, 1'b0, 32'h103, 32'h0, 0, 0, got);
      chk("lbu_value", got, 32'h00000080);

      set_word(32'h80, 32'hDEADBEEF);
      txn(1'b1, 1, 1'b0, 32'h202, 32'h1234ABCD, 0, 0, got);
      chk("sh_rd_addr", last_rd_addr, 32'h200);
      chk("sh_wdata", last_wr_data, 32'hABCDBEEF);

      txn(1'b0, 2, 1'b0, 32'h101, 32'h0, 0, 0, got);
      txn(1'b1, 1, 1'b0, 32'h203, 32'h5555AAAA, 0, 0, got);
      txn(1'b0, 3, 1'b0, 32'h100, 32'h0, 0, 0, got);

      set_word(32'hC0, 32'h0);
      txn(1'b1, 2, 1'b0, 32'h300, 32'hCAFEF00D, 3, 0, got);
      chk("sw_addr", last_wr_addr, 32'h300);
      chk("sw_data", last_wr_data, 32'hCAFEF00D);

      set_word(32'h0, 32'h8001FFFF);
      txn(1'b0, 1, 1'b0, 32'h2, 32'h0, 0, 4, got);
      chk("lhu_value", got, 32'h00008001);

      // Reset while a read is outstanding.
      ack_delay = 10;
      req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
      req_addr = 32'h100; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("mid_rd_active", mem_rd, 1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mrst_mem_rd", mem_rd, 0);
      chk("mrst_mem_wr", mem_wr, 0);
      chk("mrst_mem_addr", mem_addr, 0);
      chk("mrst_rsp_valid", rsp_valid, 0);
      chk("mrst_rsp_rdata", rsp_rdata, 0);
      chk("mrst_req_ready", req_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;
      ack_delay = 0;
      @(negedge clk);

      for (int i = 0; i < 16; i++) set_word(i, $urandom);
      for (int t = 0; t < 40; t++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
         txn(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             a, $urandom, $urandom_range(0, 2), $urandom_range(0, 1), got);
      end

      mem64_word = 64'h8000000011111111;
      t64(2, 1'b1, 32'h4, rd64, err64);
      chk("d64_lw_value", rd64, 64'hFFFFFFFF80000000);
      chk("d64_lw_err", err64, 0);
      t64(3, 1'b1, 32'h8, rd64, err64);
      chk("d64_ld_value", rd64, 64'h8000000011111111);
      chk("d64_ld_err", err64, 0);
      t64(3, 1'b0, 32'h4, rd64, err64);
      chk("d64_ld_mis_value", rd64, 64'h0);
      chk("d64_ld_mis_err", err64, 1);
      t64(0, 1'b1, 32'h7, rd64, err64);
      chk("d64_lb_value", rd64, 64'hFFFFFFFFFFFFFF80);
      t64(1, 1'b0, 32'h2, rd64, err64);
      chk("d64_lhu_value", rd64, 64'h0000000000001111);

      lat = 0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
